// File: rtl/if_fetcher.sv
// Byte-serial instruction fetcher: assembles a 32-bit little-endian instruction
// from four single-byte memory reads, with flush, branch hold and misalign handling.
module if_fetcher (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        branch_hold,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        inst_misalign,
  output logic        IFetch_stall
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 2;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  k, k_d;
  logic [XLEN-1:0]   base, base_d;
  logic [XLEN-1:0]   inst_d;
  logic              mis, mis_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      k     <= '0;
      base  <= '0;
      inst  <= '0;
      mis   <= 1'b0;
    end else begin
      state <= state_d;
      k     <= k_d;
      base  <= base_d;
      inst  <= inst_d;
      mis   <= mis_d;
    end
  end

  // Next-state, datapath updates and combinational outputs
  always_comb begin
    state_d       = state;
    k_d           = k;
    base_d        = base;
    inst_d        = inst;
    mis_d         = mis;
    mem_req       = 1'b0;
    mem_addr      = '0;
    inst_valid    = 1'b0;
    inst_misalign = 1'b0;
    IFetch_stall  = 1'b0;

    case (state)
      S_IDLE: begin
        if (!flush && !branch_hold) begin
          IFetch_stall = 1'b1;
          if (pc[1:0] != 2'b00) begin
            // Misaligned pc: hand a NOP to decode without touching memory
            inst_d  = NOP_INST;
            mis_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            base_d  = pc;
            k_d     = '0;
            mis_d   = 1'b0;
            state_d = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        mem_req      = 1'b1;
        mem_addr     = base + XLEN'(k);
        IFetch_stall = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else if (mem_ack) begin
          inst_d[{k, 3'b000} +: BYTE_W] = mem_rdata;
          k_d = k + CNT_W'(1);
          if (k == CNT_W'(3)) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        inst_valid    = !flush;
        inst_misalign = mis && !flush;
        state_d       = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Reset quiets every output regardless of the registered state
    if (rst) begin
      mem_req       = 1'b0;
      mem_addr      = '0;
      inst_valid    = 1'b0;
      inst_misalign = 1'b0;
      IFetch_stall  = 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetcher.sv
// Bench for if_fetcher: directed scenarios plus randomized fetches checked
// against a transaction-level memory/instruction model.
module tb_if_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        branch_hold;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_misalign;
  logic        IFetch_stall;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_inst;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  if_fetcher dut (
    .clk(clk), .rst(rst), .pc(pc), .branch_hold(branch_hold), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst(inst), .inst_valid(inst_valid), .inst_misalign(inst_misalign),
    .IFetch_stall(IFetch_stall)
  );

  // Memory contents as a fixed function of the byte address
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return (a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; pc = 32'h0000_1000; branch_hold = 1'b0; flush = 1'b0;
    mem_ack = 1'b1; mem_rdata = 8'hFF;
    tick;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req c%0d: got %b exp 0", i, mem_req); end
      n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid c%0d: got %b exp 0", i, inst_valid); end
      n_tests++; if (IFetch_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall c%0d: got %b exp 0", i, IFetch_stall); end
      n_tests++; if (inst_misalign !== 1'b0) begin n_fail++; $display("FAIL reset_mis c%0d: got %b exp 0", i, inst_misalign); end
      n_tests++; if (inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst c%0d: got %h exp 0", i, inst); end
      tick;
    end
    rst = 1'b0; branch_hold = 1'b1; mem_ack = 1'b0;
    tick;
    last_inst = 32'h0;
  endtask

  task automatic test_basic;
    logic [7:0] b [4];
    b[0] = 8'h13; b[1] = 8'h05; b[2] = 8'h10; b[3] = 8'h00;
    pc = 32'h0000_1000; branch_hold = 1'b0; flush = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h00;
    #1;
    n_tests++; if (IFetch_stall !== 1'b1) begin n_fail++; $display("FAIL basic_start_stall: got %b exp 1", IFetch_stall); end
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL basic_start_req: got %b exp 0", mem_req); end
    tick;
    branch_hold = 1'b1; pc = $urandom;
    for (int i = 0; i < 4; i++) begin
      mem_rdata = b[i];
      #1;
      n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL basic_req b%0d: got %b exp 1", i, mem_req); end
      n_tests++; if (mem_addr !== 32'h1000 + 32'(i)) begin n_fail++; $display("FAIL basic_addr b%0d: got %h exp %h", i, mem_addr, 32'h1000 + 32'(i)); end
      n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid b%0d: got %b exp 0", i, inst_valid); end
      tick;
    end
    mem_ack = 1'b0;
    #1;
    n_tests++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b exp 1", inst_valid); end
    n_tests++; if (inst !== 32'h0010_0513) begin n_fail++; $display("FAIL basic_inst: got %h exp 00100513", inst); end
    n_tests++; if (IFetch_stall !== 1'b0) begin n_fail++; $display("FAIL basic_done_stall: got %b exp 0", IFetch_stall); end
    n_tests++; if (inst_misalign !== 1'b0) begin n_fail++; $display("FAIL basic_mis: got %b exp 0", inst_misalign); end
    tick;
    #1;
    n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_pulse: got %b exp 0", inst_valid); end
    n_tests++; if (inst !== 32'h0010_0513) begin n_fail++; $display("FAIL basic_inst_hold: got %h exp 00100513", inst); end
    tick;
    last_inst = 32'h0010_0513;
  endtask

  task automatic test_ack_wait;
    logic [31:0] exp_addr;
    logic        exp_req;
    for (int c = 1; c <= 8; c++) begin
      pc = (c == 1) ? 32'h0000_1000 : $urandom;
      branch_hold = (c != 1);
      flush = 1'b0;
      mem_ack = !(c == 3 || c == 4);
      mem_rdata = mem_byte(mem_addr);
      #1;
      exp_req  = (c >= 2 && c <= 7);
      exp_addr = 32'h1000 + ((c == 2) ? 32'd0 : (c <= 5) ? 32'd1 : 32'(c - 4));
      n_tests++; if (mem_req !== exp_req) begin n_fail++; $display("FAIL wait_req c%0d: got %b exp %b", c, mem_req, exp_req); end
      n_tests++; if (IFetch_stall !== (c <= 7)) begin n_fail++; $display("FAIL wait_stall c%0d: got %b exp %b", c, IFetch_stall, (c <= 7)); end
      n_tests++; if (inst_valid !== (c == 8)) begin n_fail++; $display("FAIL wait_valid c%0d: got %b exp %b", c, inst_valid, (c == 8)); end
      if (exp_req) begin
        n_tests++; if (mem_addr !== exp_addr) begin n_fail++; $display("FAIL wait_addr c%0d: got %h exp %h", c, mem_addr, exp_addr); end
      end
      if (c == 8) begin
        n_tests++; if (inst !== mem_word(32'h1000)) begin n_fail++; $display("FAIL wait_inst: got %h exp %h", inst, mem_word(32'h1000)); end
      end
      tick;
    end
    mem_ack = 1'b0;
    last_inst = mem_word(32'h1000);
  endtask

  task automatic test_flush;
    logic [31:0] exp_inst;
    pc = 32'h0000_3000; branch_hold = 1'b0; flush = 1'b0; mem_ack = 1'b1;
    tick;
    branch_hold = 1'b1; pc = $urandom;
    for (int i = 0; i < 3; i++) begin
      mem_rdata = mem_byte(mem_addr);
      flush = (i == 2);
      #1;
      n_tests++; if (mem_addr !== 32'h3000 + 32'(i)) begin n_fail++; $display("FAIL flush_addr b%0d: got %h exp %h", i, mem_addr, 32'h3000 + 32'(i)); end
      tick;
    end
    flush = 1'b0;
    exp_inst = {last_inst[31:16], mem_byte(32'h3001), mem_byte(32'h3000)};
    #1;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL flush_req_after: got %b exp 0", mem_req); end
    n_tests++; if (IFetch_stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall_after: got %b exp 0", IFetch_stall); end
    n_tests++; if (inst !== exp_inst) begin n_fail++; $display("FAIL flush_discard: got %h exp %h", inst, exp_inst); end
    tick;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_valid c%0d: got %b exp 0", c, inst_valid); end
      tick;
    end
    pc = 32'h0000_2000; branch_hold = 1'b0;
    tick;
    branch_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_rdata = mem_byte(mem_addr);
      #1;
      n_tests++; if (mem_addr !== 32'h2000 + 32'(i)) begin n_fail++; $display("FAIL refetch_addr b%0d: got %h exp %h", i, mem_addr, 32'h2000 + 32'(i)); end
      tick;
    end
    #1;
    n_tests++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL refetch_valid: got %b exp 1", inst_valid); end
    n_tests++; if (inst !== mem_word(32'h2000)) begin n_fail++; $display("FAIL refetch_inst: got %h exp %h", inst, mem_word(32'h2000)); end
    tick;
    mem_ack = 1'b0;
    last_inst = mem_word(32'h2000);
  endtask

  task automatic test_branch_hold;
    pc = 32'h0000_4000; branch_hold = 1'b1; flush = 1'b0; mem_ack = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req c%0d: got %b exp 0", c, mem_req); end
      n_tests++; if (IFetch_stall !== 1'b0) begin n_fail++; $display("FAIL hold_stall c%0d: got %b exp 0", c, IFetch_stall); end
      tick;
    end
    branch_hold = 1'b0;
    #1;
    n_tests++; if (IFetch_stall !== 1'b1) begin n_fail++; $display("FAIL hold_release_stall: got %b exp 1", IFetch_stall); end
    tick;
    branch_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_rdata = mem_byte(mem_addr);
      #1;
      n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL hold_fetch_req b%0d: got %b exp 1", i, mem_req); end
      n_tests++; if (mem_addr !== 32'h4000 + 32'(i)) begin n_fail++; $display("FAIL hold_addr b%0d: got %h exp %h", i, mem_addr, 32'h4000 + 32'(i)); end
      tick;
    end
    #1;
    n_tests++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid: got %b exp 1", inst_valid); end
    n_tests++; if (inst !== mem_word(32'h4000)) begin n_fail++; $display("FAIL hold_inst: got %h exp %h", inst, mem_word(32'h4000)); end
    tick;
    mem_ack = 1'b0;
    last_inst = mem_word(32'h4000);
  endtask

  task automatic test_misalign;
    pc = 32'h0000_1002; branch_hold = 1'b0; flush = 1'b0; mem_ack = 1'b1;
    #1;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL mis_req1: got %b exp 0", mem_req); end
    tick;
    branch_hold = 1'b1;
    #1;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL mis_req2: got %b exp 0", mem_req); end
    n_tests++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL mis_valid: got %b exp 1", inst_valid); end
    n_tests++; if (inst !== NOP) begin n_fail++; $display("FAIL mis_inst: got %h exp %h", inst, NOP); end
    n_tests++; if (inst_misalign !== 1'b1) begin n_fail++; $display("FAIL mis_flag: got %b exp 1", inst_misalign); end
    tick;
    #1;
    n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL mis_pulse: got %b exp 0", inst_valid); end
    n_tests++; if (inst_misalign !== 1'b0) begin n_fail++; $display("FAIL mis_flag_idle: got %b exp 0", inst_misalign); end
    tick;
    mem_ack = 1'b0;
    last_inst = NOP;
  endtask

  task automatic test_flush_done;
    pc = 32'h0000_5000; branch_hold = 1'b0; flush = 1'b1; mem_ack = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_tests++; if (IFetch_stall !== 1'b0) begin n_fail++; $display("FAIL fidle_stall c%0d: got %b exp 0", c, IFetch_stall); end
      n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fidle_req c%0d: got %b exp 0", c, mem_req); end
      tick;
    end
    flush = 1'b0;
    tick;
    branch_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_rdata = mem_byte(mem_addr);
      tick;
    end
    flush = 1'b1;
    #1;
    n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL fdone_valid: got %b exp 0", inst_valid); end
    tick;
    flush = 1'b0;
    #1;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fdone_req_after: got %b exp 0", mem_req); end
    n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL fdone_valid_after: got %b exp 0", inst_valid); end
    n_tests++; if (inst !== mem_word(32'h5000)) begin n_fail++; $display("FAIL fdone_inst: got %h exp %h", inst, mem_word(32'h5000)); end
    tick;
    mem_ack = 1'b0;
    last_inst = mem_word(32'h5000);
  endtask

  task automatic test_wrap_rst;
    pc = 32'hFFFF_FFFC; branch_hold = 1'b0; flush = 1'b0; mem_ack = 1'b1;
    tick;
    branch_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_rdata = mem_byte(mem_addr);
      #1;
      n_tests++; if (mem_addr !== 32'hFFFF_FFFC + 32'(i)) begin n_fail++; $display("FAIL wrap_addr b%0d: got %h exp %h", i, mem_addr, 32'hFFFF_FFFC + 32'(i)); end
      tick;
    end
    #1;
    n_tests++; if (inst !== mem_word(32'hFFFF_FFFC)) begin n_fail++; $display("FAIL wrap_inst: got %h exp %h", inst, mem_word(32'hFFFF_FFFC)); end
    tick;
    branch_hold = 1'b0;
    tick;
    branch_hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mem_rdata = mem_byte(mem_addr);
      tick;
    end
    rst = 1'b1;
    #1;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req: got %b exp 0", mem_req); end
    n_tests++; if (IFetch_stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall: got %b exp 0", IFetch_stall); end
    tick;
    rst = 1'b0; mem_ack = 1'b0;
    #1;
    n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_after_addr: got %h exp 0", mem_addr); end
    n_tests++; if (inst !== 32'h0) begin n_fail++; $display("FAIL rst_after_inst: got %h exp 0", inst); end
    n_tests++; if ({mem_req, inst_valid, IFetch_stall, inst_misalign} !== 4'b0) begin n_fail++; $display("FAIL rst_after_ctl: got %b exp 0000", {mem_req, inst_valid, IFetch_stall, inst_misalign}); end
    tick;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_valid c%0d: got %b exp 0", c, inst_valid); end
      tick;
    end
    pc = 32'h0000_6000; branch_hold = 1'b0; mem_ack = 1'b1;
    tick;
    branch_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_rdata = mem_byte(mem_addr);
      #1;
      n_tests++; if (mem_addr !== 32'h6000 + 32'(i)) begin n_fail++; $display("FAIL restart_addr b%0d: got %h exp %h", i, mem_addr, 32'h6000 + 32'(i)); end
      tick;
    end
    #1;
    n_tests++; if (inst_valid !== 1'b1 || inst !== mem_word(32'h6000)) begin n_fail++; $display("FAIL restart_inst: got %b/%h exp 1/%h", inst_valid, inst, mem_word(32'h6000)); end
    tick;
    mem_ack = 1'b0;
    last_inst = mem_word(32'h6000);
  endtask

  task automatic test_random;
    for (int t = 0; t < 30; t++) begin
      logic [31:0] a;
      logic [31:0] exp_inst;
      int holds, acks, cyc;
      bit fin;
      holds = $urandom_range(0, 2);
      a = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        if (a[1:0] == 2'b00) a[1:0] = 2'b01;
      end else begin
        a[1:0] = 2'b00;
      end
      flush = 1'b0; mem_ack = 1'b0;
      for (int h = 0; h < holds; h++) begin
        branch_hold = 1'b1; pc = $urandom;
        #1;
        n_tests++; if (mem_req !== 1'b0 || IFetch_stall !== 1'b0) begin n_fail++; $display("FAIL rnd_hold t%0d: got req=%b stall=%b exp 0/0", t, mem_req, IFetch_stall); end
        tick;
      end
      branch_hold = 1'b0; pc = a; mem_ack = 1'($urandom);
      #1;
      n_tests++; if (IFetch_stall !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rnd_start t%0d: got stall=%b req=%b exp 1/0", t, IFetch_stall, mem_req); end
      tick;
      pc = $urandom; branch_hold = 1'($urandom);
      if (a[1:0] != 2'b00) begin
        #1;
        n_tests++; if (inst_valid !== 1'b1 || inst !== NOP || inst_misalign !== 1'b1 || mem_req !== 1'b0) begin
          n_fail++; $display("FAIL rnd_mis t%0d: got v=%b inst=%h m=%b req=%b exp 1/%h/1/0", t, inst_valid, inst, inst_misalign, mem_req, NOP);
        end
        tick;
        last_inst = NOP;
      end else begin
        acks = 0; fin = 1'b0; cyc = 0; exp_inst = last_inst;
        while (!fin && cyc < 200) begin
          cyc++;
          if (acks == 4) begin
            flush = 1'b0;
            #1;
            n_tests++; if (inst_valid !== 1'b1 || inst !== exp_inst || inst_misalign !== 1'b0 || IFetch_stall !== 1'b0) begin
              n_fail++; $display("FAIL rnd_done t%0d: got v=%b inst=%h m=%b st=%b exp 1/%h/0/0", t, inst_valid, inst, inst_misalign, IFetch_stall, exp_inst);
            end
            last_inst = exp_inst; fin = 1'b1;
            tick;
          end else begin
            mem_ack = ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0;
            flush = ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0;
            mem_rdata = mem_byte(mem_addr);
            #1;
            n_tests++; if (mem_req !== 1'b1 || mem_addr !== a + 32'(acks) || inst_valid !== 1'b0 || IFetch_stall !== 1'b1) begin
              n_fail++; $display("FAIL rnd_fetch t%0d k%0d: got req=%b addr=%h v=%b st=%b exp 1/%h/0/1", t, acks, mem_req, mem_addr, inst_valid, IFetch_stall, a + 32'(acks));
            end
            if (flush) begin
              tick;
              flush = 1'b0; branch_hold = 1'b1;
              #1;
              n_tests++; if (mem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== exp_inst) begin
                n_fail++; $display("FAIL rnd_flush t%0d: got req=%b v=%b inst=%h exp 0/0/%h", t, mem_req, inst_valid, inst, exp_inst);
              end
              last_inst = exp_inst; fin = 1'b1;
              tick;
            end else begin
              if (mem_ack) begin
                exp_inst[8*acks +: 8] = mem_byte(a + 32'(acks));
                acks++;
              end
              tick;
            end
          end
        end
        if (!fin) begin
          n_tests++; n_fail++;
          $display("FAIL rnd_timeout t%0d: got no delivery in %0d cycles exp delivery", t, cyc);
        end
      end
    end
    flush = 1'b0; mem_ack = 1'b0; branch_hold = 1'b1;
    tick;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ack_wait();
    test_flush();
    test_branch_hold();
    test_misalign();
    test_flush_done();
    test_wrap_rst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion exp finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
